// File: rtl/fpu_share_sched.sv
// Round-robin front end that time-shares one FPU datapath among NREQ requesters.
// Accepts one op at a time, turns sub into add with B negated, and returns the tagged result.
module fpu_share_sched #(
  parameter int NREQ    = 4,
  parameter int LAT_ADD = 1,
  parameter int LAT_MUL = 2,
  parameter int LAT_DIV = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [2*NREQ-1:0]        req_op,
  input  logic [32*NREQ-1:0]       req_a,
  input  logic [32*NREQ-1:0]       req_b,
  output logic [1:0]               fpu_sel,
  output logic [31:0]              fpu_a,
  output logic [31:0]              fpu_b,
  output logic                     fpu_start,
  input  logic [31:0]              fpu_s,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [31:0]              rsp_data,
  output logic                     busy
);
  localparam int IW   = $clog2(NREQ);
  localparam int LMX1 = (LAT_ADD > LAT_MUL) ? LAT_ADD : LAT_MUL;
  localparam int LMAX = (LMX1 > LAT_DIV) ? LMX1 : LAT_DIV;
  localparam int CW   = (LMAX > 1) ? $clog2(LMAX) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            fpu_start_q, fpu_start_d;
  logic [31:0]     rsp_data_q, rsp_data_d;
  logic [IW-1:0]   rsp_id_q, rsp_id_d;
  logic [31:0]     fpu_a_q, fpu_a_d;
  logic [31:0]     fpu_b_q, fpu_b_d;
  logic [1:0]      fpu_sel_q, fpu_sel_d;

  logic [NREQ-1:0][1:0]  op_v;
  logic [NREQ-1:0][31:0] a_v, b_v;
  assign op_v = req_op;
  assign a_v  = req_a;
  assign b_v  = req_b;

  logic [NREQ-1:0] gnt_oh;
  logic [IW-1:0]   gnt_idx;
  logic            gnt_any;
  int              idx;

  // Search upward from ptr+1 with wrap; first valid requester wins.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any     = 1'b1;
        gnt_idx     = idx[IW-1:0];
        gnt_oh[idx] = 1'b1;
      end
    end
  end

  logic [1:0]    op_g, sel_g;
  logic [31:0]   a_g, b_g;
  logic [CW-1:0] lat_g;

  always_comb begin
    op_g  = op_v[gnt_idx];
    a_g   = a_v[gnt_idx];
    b_g   = (op_g == 2'b01) ? {~b_v[gnt_idx][31], b_v[gnt_idx][30:0]} : b_v[gnt_idx];
    sel_g = (op_g == 2'b01) ? 2'b00 : op_g;
    case (op_g)
      2'b10:   lat_g = CW'(LAT_MUL - 1);
      2'b11:   lat_g = CW'(LAT_DIV - 1);
      default: lat_g = CW'(LAT_ADD - 1);
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    fpu_start_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    fpu_a_d     = fpu_a_q;
    fpu_b_d     = fpu_b_q;
    fpu_sel_d   = fpu_sel_q;
    req_ready   = '0;
    case (state_q)
      IDLE: if (gnt_any) begin
        req_ready   = gnt_oh;
        fpu_a_d     = a_g;
        fpu_b_d     = b_g;
        fpu_sel_d   = sel_g;
        rsp_id_d    = gnt_idx;
        cnt_d       = lat_g;
        fpu_start_d = 1'b1;
        state_d     = EXEC;
      end
      EXEC: if (cnt_q == '0) begin
        rsp_data_d  = fpu_s;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      RESP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        ptr_d       = rsp_id_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Nothing may be accepted while reset is held, even from IDLE.
    if (rst) req_ready = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= IW'(NREQ - 1);
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      fpu_start_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      fpu_a_q     <= '0;
      fpu_b_q     <= '0;
      fpu_sel_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      fpu_start_q <= fpu_start_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      fpu_a_q     <= fpu_a_d;
      fpu_b_q     <= fpu_b_d;
      fpu_sel_q   <= fpu_sel_d;
    end
  end

  assign fpu_sel   = fpu_sel_q;
  assign fpu_a     = fpu_a_q;
  assign fpu_b     = fpu_b_q;
  assign fpu_start = fpu_start_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_fpu_share_sched.sv
// Directed bench for fpu_share_sched with a small latency-accurate FPU stand-in.
module tb_fpu_share_sched;
  localparam int NREQ = 4, LAT_ADD = 1, LAT_MUL = 2, LAT_DIV = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [2*NREQ-1:0] req_op = '0;
  logic [32*NREQ-1:0] req_a = '0, req_b = '0;
  logic [1:0]        fpu_sel;
  logic [31:0]       fpu_a, fpu_b, fpu_s;
  logic              fpu_start, rsp_valid, busy;
  logic              rsp_ready = 1'b0;
  logic [1:0]        rsp_id;
  logic [31:0]       rsp_data;

  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  fpu_share_sched #(.NREQ(NREQ), .LAT_ADD(LAT_ADD), .LAT_MUL(LAT_MUL), .LAT_DIV(LAT_DIV)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .fpu_sel(fpu_sel), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_start(fpu_start), .fpu_s(fpu_s), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy));

  // FPU stand-in: result only valid once the unit's latency has elapsed since start.
  int age;
  always_ff @(posedge clk)
    if (rst) age <= 0;
    else if (fpu_start) age <= 1;
    else if (age != 0 && age < 1000) age <= age + 1;

  function automatic int lat_of(input logic [1:0] s);
    case (s)
      2'b10:   return LAT_MUL;
      2'b11:   return LAT_DIV;
      default: return LAT_ADD;
    endcase
  endfunction

  function automatic logic [31:0] fpu_model(input logic [1:0] s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = 32'h0BADF00D;
    if (s == 2'b00 && a == 32'h3F800000 && b == 32'h40000000) r = 32'h40400000;
    if (s == 2'b00 && a == 32'h40400000 && b == 32'hBF800000) r = 32'h40000000;
    if (s == 2'b00 && a == 32'h7F800000 && b == 32'hFF800000) r = 32'h7FFFFFFF;
    if (s == 2'b10 && a == 32'h40000000 && b == 32'h40400000) r = 32'h40C00000;
    if (s == 2'b11 && a == 32'h40C00000 && b == 32'h40000000) r = 32'h40400000;
    if (s == 2'b11 && a == 32'h41000000 && b == 32'h40000000) r = 32'h40800000;
    if (s == 2'b11 && a == 32'h40800000 && b == 32'h40000000) r = 32'h40000000;
    if (s == 2'b11 && a == 32'h40000000 && b == 32'h40000000) r = 32'h3F800000;
    if (s == 2'b11 && a == 32'h00000000 && b == 32'h00000000) r = 32'h7FFFFFFF;
    return r;
  endfunction

  logic fpu_rdy;
  assign fpu_rdy = fpu_start ? (lat_of(fpu_sel) == 1) : (age != 0 && age >= lat_of(fpu_sel) - 1);
  assign fpu_s   = fpu_rdy ? fpu_model(fpu_sel, fpu_a, fpu_b) : 32'hDEADBEEF;

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[2*i +: 2] = op;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'b1111; rsp_ready = 1'b0;
    step(); step();
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL rst_req_ready: got %b want 0000", req_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (fpu_start !== 1'b0) begin n_bad++; $display("FAIL rst_fpu_start: got %b want 0", fpu_start); end
    n_cmp++; if ({fpu_a, fpu_b, fpu_sel} !== 66'd0) begin n_bad++; $display("FAIL rst_fpu_regs: got a=%h b=%h sel=%b want 0", fpu_a, fpu_b, fpu_sel); end
    n_cmp++; if ({rsp_data, rsp_id} !== 34'd0) begin n_bad++; $display("FAIL rst_rsp_regs: got data=%h id=%0d want 0", rsp_data, rsp_id); end
    req_valid = '0; rst = 1'b0;
    step();
    n_cmp++; if (busy !== 1'b0 || req_ready !== 4'b0000) begin n_bad++; $display("FAIL post_rst_idle: got busy=%b ready=%b want 0/0000", busy, req_ready); end
  endtask

  task automatic test_single_add();
    set_req(0, 2'b00, 32'h3F800000, 32'h40000000);
    req_valid = 4'b0001; rsp_ready = 1'b1; #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL add_grant: got %b want 0001", req_ready); end
    step(); req_valid = '0; #1;
    n_cmp++; if (fpu_start !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL add_start: got start=%b busy=%b want 1/1", fpu_start, busy); end
    n_cmp++; if (fpu_sel !== 2'b00 || fpu_a !== 32'h3F800000 || fpu_b !== 32'h40000000) begin n_bad++; $display("FAIL add_operands: got sel=%b a=%h b=%h want 00/3f800000/40000000", fpu_sel, fpu_a, fpu_b); end
    n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin n_bad++; $display("FAIL add_exec_quiet: got rsp_valid=%b ready=%b want 0/0000", rsp_valid, req_ready); end
    step();
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h40400000 || rsp_id !== 2'd0) begin n_bad++; $display("FAIL add_rsp: got v=%b data=%h id=%0d want 1/40400000/0", rsp_valid, rsp_data, rsp_id); end
    n_cmp++; if (fpu_start !== 1'b0) begin n_bad++; $display("FAIL add_start_pulse: got %b want 0", fpu_start); end
    step();
    n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL add_done: got v=%b busy=%b want 0/0", rsp_valid, busy); end
  endtask

  task automatic test_sub_flip();
    set_req(0, 2'b00, 32'h12345678, 32'h9ABCDEF0);
    set_req(2, 2'b01, 32'h40400000, 32'h3F800000);
    req_valid = 4'b0100; rsp_ready = 1'b1; #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL sub_grant: got %b want 0100", req_ready); end
    step(); req_valid = '0; #1;
    n_cmp++; if (fpu_sel !== 2'b00 || fpu_b !== 32'hBF800000 || fpu_a !== 32'h40400000) begin n_bad++; $display("FAIL sub_flip: got sel=%b a=%h b=%h want 00/40400000/bf800000", fpu_sel, fpu_a, fpu_b); end
    step();
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h40000000 || rsp_id !== 2'd2) begin n_bad++; $display("FAIL sub_rsp: got v=%b data=%h id=%0d want 1/40000000/2", rsp_valid, rsp_data, rsp_id); end
    step();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL sub_done: got busy=%b want 0", busy); end
  endtask

  task automatic test_round_robin();
    logic [31:0] da [4];
    logic [31:0] dq [4];
    logic [3:0]  exp_oh;
    logic        bad_mid;
    int          g;
    da[0] = 32'h40C00000; dq[0] = 32'h40400000;
    da[1] = 32'h41000000; dq[1] = 32'h40800000;
    da[2] = 32'h40800000; dq[2] = 32'h40000000;
    da[3] = 32'h40000000; dq[3] = 32'h3F800000;
    rst = 1'b1; req_valid = '0; step(); rst = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 2'b11, da[i], 32'h40000000);
    req_valid = 4'b1111; rsp_ready = 1'b1; #1;
    for (int k = 0; k < 5; k++) begin
      g = k % 4;
      exp_oh = 4'b0001 << g;
      n_cmp++; if (req_ready !== exp_oh) begin n_bad++; $display("FAIL rr_grant%0d: got %b want %b", k, req_ready, exp_oh); end
      step();
      if (k == 4) req_valid = '0;
      bad_mid = 1'b0;
      for (int c = 1; c < 9; c++) begin
        if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) bad_mid = 1'b1;
        step();
      end
      n_cmp++; if (bad_mid !== 1'b0) begin n_bad++; $display("FAIL rr_exec_quiet%0d: got early rsp_valid/req_ready, want none before cycle 9", k); end
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(g) || rsp_data !== dq[g]) begin n_bad++; $display("FAIL rr_rsp%0d: got v=%b id=%0d data=%h want 1/%0d/%h", k, rsp_valid, rsp_id, rsp_data, g, dq[g]); end
      step();
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rr_done: got busy=%b want 0", busy); end
  endtask

  task automatic test_backpressure();
    set_req(1, 2'b10, 32'h40000000, 32'h40400000);
    set_req(3, 2'b00, 32'h3F800000, 32'h40000000);
    rsp_ready = 1'b0; req_valid = 4'b0010; #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL bp_grant: got %b want 0010", req_ready); end
    step(); req_valid = 4'b1010; #1;
    n_cmp++; if (fpu_sel !== 2'b10 || fpu_start !== 1'b1) begin n_bad++; $display("FAIL bp_mul_start: got sel=%b start=%b want 10/1", fpu_sel, fpu_start); end
    step();
    n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin n_bad++; $display("FAIL bp_exec2: got v=%b ready=%b want 0/0000", rsp_valid, req_ready); end
    step();
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h40C00000 || rsp_id !== 2'd1 || req_ready !== 4'b0000)
        begin n_bad++; $display("FAIL bp_hold%0d: got v=%b data=%h id=%0d ready=%b want 1/40c00000/1/0000", i, rsp_valid, rsp_data, rsp_id, req_ready); end
      step();
    end
    rsp_ready = 1'b1; #1;
    n_cmp++; if (req_ready !== 4'b0000 || rsp_valid !== 1'b1) begin n_bad++; $display("FAIL bp_handshake: got ready=%b v=%b want 0000/1", req_ready, rsp_valid); end
    step();
    n_cmp++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL bp_next_grant: got %b want 1000", req_ready); end
    step(); req_valid = '0;
    step();
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h40400000 || rsp_id !== 2'd3) begin n_bad++; $display("FAIL bp_req3_rsp: got v=%b data=%h id=%0d want 1/40400000/3", rsp_valid, rsp_data, rsp_id); end
    step();
  endtask

  task automatic test_special();
    int c;
    set_req(0, 2'b01, 32'h7F800000, 32'h7F800000);
    req_valid = 4'b0001; rsp_ready = 1'b1; #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL inf_grant: got %b want 0001", req_ready); end
    step(); req_valid = '0; #1;
    n_cmp++; if (fpu_b !== 32'hFF800000 || fpu_sel !== 2'b00) begin n_bad++; $display("FAIL inf_flip: got b=%h sel=%b want ff800000/00", fpu_b, fpu_sel); end
    step();
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h7FFFFFFF) begin n_bad++; $display("FAIL inf_rsp: got v=%b data=%h want 1/7fffffff", rsp_valid, rsp_data); end
    step();
    set_req(0, 2'b11, 32'h00000000, 32'h00000000);
    req_valid = 4'b0001; #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL div0_grant: got %b want 0001", req_ready); end
    step(); req_valid = '0; c = 1;
    while (rsp_valid !== 1'b1 && c < 20) begin step(); c++; end
    n_cmp++; if (c != 9) begin n_bad++; $display("FAIL div0_latency: got %0d want 9", c); end
    n_cmp++; if (rsp_data !== 32'h7FFFFFFF || rsp_id !== 2'd0) begin n_bad++; $display("FAIL div0_rsp: got data=%h id=%0d want 7fffffff/0", rsp_data, rsp_id); end
    step();
  endtask

  task automatic test_reset_mid_op();
    set_req(0, 2'b11, 32'h41000000, 32'h40000000);
    set_req(1, 2'b00, 32'h3F800000, 32'h40000000);
    req_valid = 4'b0001; rsp_ready = 1'b1; #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL rmo_grant: got %b want 0001", req_ready); end
    step(); req_valid = '0;
    step(); step();
    rst = 1'b1;
    step(); rst = 1'b0; #1;
    n_cmp++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || fpu_start !== 1'b0) begin n_bad++; $display("FAIL rmo_ctrl: got busy=%b v=%b start=%b want 0/0/0", busy, rsp_valid, fpu_start); end
    n_cmp++; if ({fpu_a, fpu_b, fpu_sel} !== 66'd0 || {rsp_data, rsp_id} !== 34'd0) begin n_bad++; $display("FAIL rmo_regs: got a=%h b=%h sel=%b data=%h id=%0d want all 0", fpu_a, fpu_b, fpu_sel, rsp_data, rsp_id); end
    req_valid = 4'b0011; #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL rmo_prio: got %b want 0001", req_ready); end
    req_valid = 4'b0010; #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL rmo_req1: got %b want 0010", req_ready); end
    step(); req_valid = '0;
    step();
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h40400000 || rsp_id !== 2'd1) begin n_bad++; $display("FAIL rmo_rsp: got v=%b data=%h id=%0d want 1/40400000/1", rsp_valid, rsp_data, rsp_id); end
    step();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmo_done: got busy=%b want 0", busy); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_add();
    test_sub_flip();
    test_round_robin();
    test_backpressure();
    test_special();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
